lcd_fill_scheduler: RTL and testbench
=====================================

# lcd_fill_scheduler

Arbitrates between up to four frame-fill requesters and sequences the shared LCD colour-fill engine on their behalf. Each request carries an RGB565 colour. The scheduler picks one winner and performs the engine's reset handshake. It then enables the fill, watches for completion or timeout, and returns a one-cycle acknowledge to the winner. It sits between application logic and the fill engine, downstream of the LCD init sequencer (`init_done`).

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `FILL_TIMEOUT`, 600000: RUN cycles allowed before abort; range 1..2^32-1.
- `clk`  in  1: sole clock, all logic on posedge.
- `reset_states`  in  1: synchronous, active-high reset.
- `init_done`  in  1: LCD init complete; no grant is issued while low.
- `req`  in  NUM_REQ: level request per requester, held until its `ack`.
- `req_color`  in  16*NUM_REQ: RGB565 colour; requester i uses bits [16i+15:16i].
- `ack`  out  NUM_REQ: one-cycle completion pulse to the granted requester.
- `err`  out  1: one-cycle pulse coincident with `ack` when the fill was aborted.
- `busy`  out  1: high from grant through the ack cycle.
- `grant_id`  out  2: index of the current or last winner.
- `fill_color`  out  16: to the engine's `input_color`; stable from RESET through DONE.
- `fill_reset`  out  1: to the engine's `reset_states`.
- `fill_enable`  out  1: to the engine's `init_done`.
- `fill_reset_done`  in  1: engine `reset_done`.
- `fill_done`  in  1: engine `fill_done`.

## Operation
- All outputs are registered. Reset values: `ack`=0, `err`=0, `busy`=0, `grant_id`=0, `fill_color`=16'h0000, `fill_reset`=0, `fill_enable`=0.
- On reset, the state goes to IDLE, the RR pointer to 0 and the timer to 0.
- **IDLE**
  - If `init_done`=1 and `req` is nonzero, pick a winner.
  - Latch `grant_id` and `fill_color` from the winner's `req_color` slice, set `busy`=1, then go to RESET.
- **RESET**
  - Drive `fill_reset`=1 and `fill_enable`=0 for exactly one cycle, then go to WAIT_RST.
- **WAIT_RST**
  - Hold `fill_reset`=0.
  - When `fill_reset_done`=1, set `fill_enable`=1, clear the timer, and go to RUN.
- **RUN**
  - Hold `fill_enable`=1; the timer increments every cycle.
  - `fill_done`=1: go to DONE with err flag 0.
  - Timer equals `FILL_TIMEOUT`-1: go to DONE with err flag 1.
  - `init_done`=0: go to DONE with err flag 1.
  - If several of these hold in the same cycle, `fill_done` wins and err is 0.
- **DONE**
  - Drive `fill_enable`=0, `ack[grant_id]`=1 and `err`=flag for one cycle.
  - Update the RR pointer to `grant_id`+1 modulo `NUM_REQ`.
  - Go to IDLE; `busy`=0 from the next cycle.
- A grant is committed once issued. Deasserting `req` after the grant does not cancel the fill; the ack is still issued.
- `req` bits at or above `NUM_REQ` are ignored. `req_color` of non-winners is never sampled.
- `reset_states` in any state forces the reset values on the next edge. No ack is produced for the aborted grant.

## Timing
- Grant latency:
  - `req` seen in IDLE at edge t gives `busy`, `grant_id` and `fill_color` valid, and `fill_reset`=1, after edge t+1.
  - With the engine answering `reset_done` on its reset edge, `fill_enable` rises after edge t+3.
- Completion latency: `fill_done` seen at edge d gives `ack`/`err` high for exactly the cycle after edge d+1. They drop, and `fill_enable` is low, after edge d+2.
- Back-to-back: at least one IDLE cycle separates consecutive grants; a held `req` is re-arbitrated in that cycle.
- Throughput with a real engine is about 460814 + 5 cycles per frame.

## Configuration
- `LCD_SCHED_RR_EN` defined: round-robin arbitration.
  - Search starts at the RR pointer and takes the first asserted `req` in ascending, wrapping index order.
- `LCD_SCHED_RR_EN` undefined: fixed priority, lowest index wins.
  - The RR pointer logic is removed.
- Outside the arbitration choice, handshake timing is identical in both builds.

## Test plan
- Single request, engine stub with `fill_done` 100 cycles after enable:
  - Stimulus: `req`=2'b01, colour 16'hF800.
  - Response: `fill_color`=16'hF800, one `fill_reset` pulse, `ack`=2'b01 for one cycle, `err`=0, `busy` low afterwards.
- Both requesting continuously, RR build:
  - Response: grants alternate 0,1,0,1.
  - Fixed-priority build: grants are always 0.
- Gating:
  - `init_done`=0 with `req`=2'b11: no `fill_reset` and `busy`=0 for 1000 cycles.
  - Raise `init_done`: a grant follows on the next edge.
- Timeout: `FILL_TIMEOUT`=50 with a stub that never asserts `fill_done` gives `ack` and `err` together on the 52nd cycle after `fill_enable` rises, then `fill_enable`=0.
- Aborts mid-RUN:
  - `reset_states` pulse: all outputs at reset values next cycle, no `ack`.
  - `init_done` drop: `ack` with `err`=1.
- Simultaneous events: `fill_done`=1 in the same cycle the timer expires gives `ack` with `err`=0.

Source files
------------

// File: rtl/lcd_fill_scheduler.sv
// Arbitrates up to four frame-fill requesters and sequences the shared LCD colour-fill engine.
// Define LCD_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module lcd_fill_scheduler #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned FILL_TIMEOUT = 600000
) (
    input  logic                  clk,
    input  logic                  reset_states,
    input  logic                  init_done,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_color,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  err,
    output logic                  busy,
    output logic [1:0]            grant_id,
    output logic [15:0]           fill_color,
    output logic                  fill_reset,
    output logic                  fill_enable,
    input  logic                  fill_reset_done,
    input  logic                  fill_done
);
    typedef enum logic [2:0] {S_IDLE, S_RESET, S_WAIT_RST, S_RUN, S_DONE} state_t;

    localparam logic [31:0] TIMER_LAST = 32'(FILL_TIMEOUT - 1);

    state_t             r_state;
    logic [31:0]        r_timer;
    logic               r_abort;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_err;
    logic               r_busy;
    logic [1:0]         r_grant_id;
    logic [15:0]        r_fill_color;
    logic               r_fill_reset;
    logic               r_fill_enable;

    logic               w_any;
    logic [1:0]         w_win;
    logic [15:0]        w_color;
    logic [NUM_REQ-1:0] w_ack_onehot;

`ifdef LCD_SCHED_RR_EN
    localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);

    logic [1:0]         r_rr_ptr;
    logic [NUM_REQ-1:0] w_req_rot;
    logic [2:0]         w_sum;

    // Rotating the request vector by the pointer turns the wrapping search into a lowest-bit search.
    assign w_req_rot = NUM_REQ'({req, req} >> r_rr_ptr);

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_any = 1'b0;
        w_win = 2'd0;
        w_sum = 3'd0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_rr_ptr} + 3'(i);
                if (w_sum >= 3'(NUM_REQ)) begin
                    w_win = 2'(w_sum - 3'(NUM_REQ));
                end else begin
                    w_win = w_sum[1:0];
                end
            end
        end
    end
`else
    always_comb begin
        w_any = 1'b0;
        w_win = 2'd0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_any = 1'b1;
                w_win = 2'(i);
            end
        end
    end
`endif

    always_comb begin
        w_color = 16'h0000;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_win == 2'(i)) begin
                w_color = req_color[16*i +: 16];
            end
        end
    end

    assign w_ack_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_states) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_abort       <= 1'b0;
            r_ack         <= '0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_id    <= 2'd0;
            r_fill_color  <= 16'h0000;
            r_fill_reset  <= 1'b0;
            r_fill_enable <= 1'b0;
`ifdef LCD_SCHED_RR_EN
            r_rr_ptr      <= 2'd0;
`endif
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (init_done && w_any) begin
                        r_grant_id   <= w_win;
                        r_fill_color <= w_color;
                        r_busy       <= 1'b1;
                        r_state      <= S_RESET;
                    end
                end
                S_RESET: begin
                    r_fill_reset  <= 1'b1;
                    r_fill_enable <= 1'b0;
                    r_state       <= S_WAIT_RST;
                end
                S_WAIT_RST: begin
                    r_fill_reset <= 1'b0;
                    if (fill_reset_done) begin
                        r_fill_enable <= 1'b1;
                        r_timer       <= '0;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_timer <= r_timer + 32'd1;
                    // A completion in the same cycle as an abort condition still counts as clean.
                    if (fill_done) begin
                        r_abort <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_timer == TIMER_LAST || !init_done) begin
                        r_abort <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_fill_enable <= 1'b0;
                    r_ack         <= w_ack_onehot;
                    r_err         <= r_abort;
`ifdef LCD_SCHED_RR_EN
                    r_rr_ptr      <= (r_grant_id == LAST_ID) ? 2'd0 : r_grant_id + 2'd1;
`endif
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack         = r_ack;
    assign err         = r_err;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;
    assign fill_color  = r_fill_color;
    assign fill_reset  = r_fill_reset;
    assign fill_enable = r_fill_enable;
endmodule

// File: tb/tb_lcd_fill_scheduler.sv
// Bench for lcd_fill_scheduler: table of fill transactions, random transactions against a
// transaction-level model, and hand sequences for gating, back-to-back grants and reset abort.
module tb_lcd_fill_scheduler;
    localparam int NREQ = 2;
    localparam int TMO  = 50;
`ifdef LCD_SCHED_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_states;
    logic        init_done;
    logic [1:0]  req;
    logic [31:0] req_color;
    logic [1:0]  ack;
    logic        err;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] fill_color;
    logic        fill_reset;
    logic        fill_enable;
    logic        fill_reset_done;
    logic        fill_done;

    int n_vec  = 0;
    int n_miss = 0;
    int stub_delay = 0;
    int en_cnt = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    lcd_fill_scheduler #(.NUM_REQ(NREQ), .FILL_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset_states    (reset_states),
        .init_done       (init_done),
        .req             (req),
        .req_color       (req_color),
        .ack             (ack),
        .err             (err),
        .busy            (busy),
        .grant_id        (grant_id),
        .fill_color      (fill_color),
        .fill_reset      (fill_reset),
        .fill_enable     (fill_enable),
        .fill_reset_done (fill_reset_done),
        .fill_done       (fill_done)
    );

    // Engine stub: reset_done answers on the reset edge, fill_done pulses stub_delay cycles after enable.
    always @(posedge clk) begin
        fill_reset_done <= fill_reset;
        if (fill_enable) en_cnt <= en_cnt + 1;
        else             en_cnt <= 0;
        fill_done <= fill_enable && (stub_delay != 0) && (en_cnt + 1 == stub_delay);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Winner: first asserted request searching upward from the pointer (always 0 for fixed priority).
    function automatic int pick(input logic [1:0] r);
        int start;
        int idx;
        start = RR_BUILD ? m_ptr : 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (start + k) % NREQ;
            if (((r >> idx) & 2'b01) != 2'b00) return idx;
        end
        return 0;
    endfunction

    // Edge (counted from the enable edge) at which the fill ends: earliest of completion seen,
    // init_done drop seen, or timer expiry; completion wins ties.
    function automatic int model_end(input int dly, input int drop);
        int e;
        e = TMO;
        if (drop != 0 && drop < e) e = drop;
        if (dly != 0 && dly + 1 <= e) e = dly + 1;
        return e;
    endfunction

    task automatic do_fill(input string tag, input logic [1:0] r, input logic [31:0] cols,
                           input int dly, input int drop, input int exp_gid,
                           input bit exp_err, input int exp_lat);
        int          cnt;
        logic [31:0] exp_col;
        logic [1:0]  exp_ack;
        exp_col = cols >> (16 * exp_gid);
        exp_ack = 2'b01 << exp_gid;
        @(negedge clk);
        req = r; req_color = cols; stub_delay = dly;
        @(negedge clk);
        @(negedge clk);
        check({tag, ".busy"},       32'(busy),       32'd1);
        check({tag, ".grant_id"},   32'(grant_id),   32'(exp_gid));
        check({tag, ".fill_color"}, 32'(fill_color), {16'h0000, exp_col[15:0]});
        check({tag, ".fill_reset"}, 32'(fill_reset), 32'd1);
        @(negedge clk);
        check({tag, ".reset_pulse_end"}, 32'(fill_reset),  32'd0);
        check({tag, ".enable_early"},    32'(fill_enable), 32'd0);
        @(negedge clk);
        check({tag, ".enable_rise"},     32'(fill_enable), 32'd1);
        cnt = 1;
        while (ack == 2'b00 && cnt < 200) begin
            if (drop != 0 && cnt == drop) init_done = 1'b0;
            @(negedge clk);
            cnt++;
        end
        check({tag, ".ack"},      32'(ack),  32'(exp_ack));
        check({tag, ".err"},      32'(err),  32'(exp_err));
        check({tag, ".ack_cycle"}, 32'(cnt), 32'(exp_lat));
        check({tag, ".busy_ack"}, 32'(busy), 32'd1);
        req = 2'b00; init_done = 1'b1;
        @(negedge clk);
        check({tag, ".ack_drop"},    32'(ack),         32'd0);
        check({tag, ".err_drop"},    32'(err),         32'd0);
        check({tag, ".enable_drop"}, 32'(fill_enable), 32'd0);
        m_ptr = (exp_gid + 1) % NREQ;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] colors;
        int          dly;
        int          drop;
        int          gid_rr;
        int          gid_fx;
        bit          err;
        int          lat;
    } vec_t;

    vec_t        vecs[9];
    logic [1:0]  r_rnd;
    logic [31:0] c_rnd;
    int          d_rnd, p_rnd, g_rnd, e_rnd, cnt, viol, exp_g;
    logic [31:0] exp_col;

    initial begin
        vecs[0] = '{2'b01, 32'h07E0_F800, 30, 0, 0, 0, 1'b0, 33};
        vecs[1] = '{2'b11, 32'h001F_FFE0, 10, 0, 1, 0, 1'b0, 13};
        vecs[2] = '{2'b11, 32'h1234_ABCD,  0, 0, 0, 0, 1'b1, 52};
        vecs[3] = '{2'b10, 32'hFFFF_0001, 49, 0, 1, 1, 1'b0, 52};
        vecs[4] = '{2'b11, 32'h5A5A_A5A5,  1, 0, 0, 0, 1'b0,  4};
        vecs[5] = '{2'b01, 32'h0F0F_F0F0, 50, 0, 0, 0, 1'b1, 52};
        vecs[6] = '{2'b11, 32'hC3C3_3C3C, 20, 5, 1, 0, 1'b1,  7};
        vecs[7] = '{2'b11, 32'h8001_7FFE,  4, 4, 0, 0, 1'b1,  6};
        vecs[8] = '{2'b11, 32'h2468_1357,  4, 5, 1, 0, 1'b0,  7};

        reset_states = 1'b1; init_done = 1'b0; req = 2'b00; req_color = 32'h0;
        repeat (3) @(negedge clk);
        check("rst.ack",         32'(ack),         32'd0);
        check("rst.err",         32'(err),         32'd0);
        check("rst.busy",        32'(busy),        32'd0);
        check("rst.grant_id",    32'(grant_id),    32'd0);
        check("rst.fill_color",  32'(fill_color),  32'd0);
        check("rst.fill_reset",  32'(fill_reset),  32'd0);
        check("rst.fill_enable", 32'(fill_enable), 32'd0);
        reset_states = 1'b0; init_done = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_fill($sformatf("vec%0d", i), vecs[i].req, vecs[i].colors, vecs[i].dly, vecs[i].drop,
                    RR_BUILD ? vecs[i].gid_rr : vecs[i].gid_fx, vecs[i].err, vecs[i].lat);
        end

        for (int n = 0; n < 40; n++) begin
            r_rnd = 2'($urandom_range(1, 3));
            c_rnd = $urandom;
            d_rnd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
            p_rnd = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 60)) : 0;
            g_rnd = pick(r_rnd);
            e_rnd = model_end(d_rnd, p_rnd);
            do_fill($sformatf("rnd%0d", n), r_rnd, c_rnd, d_rnd, p_rnd, g_rnd,
                    !(d_rnd != 0 && d_rnd + 1 == e_rnd), e_rnd + 2);
        end

        // Reset in the middle of RUN: outputs return to reset values and the grant is never acked.
        do_fill("pre_abort", 2'b01, 32'hAAAA_5555, 3, 0, pick(2'b01), 1'b0, 6);
        @(negedge clk);
        req = 2'b01; stub_delay = 0;
        cnt = 0;
        while (fill_enable !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("abort.reached_run", 32'(fill_enable), 32'd1);
        repeat (5) @(negedge clk);
        reset_states = 1'b1; req = 2'b00;
        @(negedge clk);
        reset_states = 1'b0;
        check("abort.ack",         32'(ack),         32'd0);
        check("abort.err",         32'(err),         32'd0);
        check("abort.busy",        32'(busy),        32'd0);
        check("abort.grant_id",    32'(grant_id),    32'd0);
        check("abort.fill_color",  32'(fill_color),  32'd0);
        check("abort.fill_reset",  32'(fill_reset),  32'd0);
        check("abort.fill_enable", 32'(fill_enable), 32'd0);
        viol = 0;
        repeat (80) begin
            @(negedge clk);
            if (ack !== 2'b00) viol++;
        end
        check("abort.no_ack", 32'(viol), 32'd0);
        m_ptr = 0;

        // Gating by init_done, then both requesters held for four back-to-back grants.
        init_done = 1'b0; req = 2'b11; req_color = 32'h001F_FFE0; stub_delay = 5;
        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (fill_reset !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("gate.idle_cycles", 32'(viol), 32'd0);
        init_done = 1'b1;
        @(negedge clk);
        check("gate.grant_next_edge", 32'(busy), 32'd1);
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            exp_g = pick(2'b11);
            exp_col = req_color >> (16 * exp_g);
            check($sformatf("b2b%0d.grant_id", g),   32'(grant_id),   32'(exp_g));
            check($sformatf("b2b%0d.fill_color", g), 32'(fill_color), {16'h0000, exp_col[15:0]});
            cnt = 0;
            while (ack == 2'b00 && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            check($sformatf("b2b%0d.ack", g), 32'(ack), 32'(2'b01 << exp_g));
            m_ptr = (exp_g + 1) % NREQ;
            if (g == 3) req = 2'b00;
            @(negedge clk);
        end
        check("b2b.busy_after", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", n_vec);
        $fatal(1);
    end
endmodule
